ntt_buffer_ram: RTL and testbench



---
 rtl/ntt_buffer_ram_pkg.sv | 15 +
 rtl/ntt_buffer_resp_fifo.sv | 37 +++
 rtl/ntt_buffer_ram.sv | 90 +++++++++
 tb/tb_ntt_buffer_ram.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_buffer_ram_pkg.sv
// ntt_buffer_ram_pkg: shared sizing constants and the controller-to-buffer bus type
package ntt_buffer_ram_pkg;
    localparam int POLY_N = 64;
    localparam int ROW_E = 4;
    localparam int COEF_FSIZE = 16;
    localparam int BUF_ADDR_W = $clog2(POLY_N) - $clog2(ROW_E);
    localparam int BUFFER_READ_LATENCY = 2;
    localparam int BUFFER_RESP_DEPTH = BUFFER_READ_LATENCY + 2;
    typedef struct packed {
        logic [BUF_ADDR_W-1:0] raddr;
        logic [BUF_ADDR_W-1:0] waddr;
        logic wren;
        logic [ROW_E*COEF_FSIZE-1:0] wdata;
    } BufferRAMTEFsizeInputs;
endpackage

// File: rtl/ntt_buffer_resp_fifo.sv
// ntt_buffer_resp_fifo: show-ahead synchronous FIFO with occupancy count
module ntt_buffer_resp_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic             valid,
    output logic [W-1:0]     pop_data,
    output logic [CNT_W-1:0] count
);
    logic [W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    // entry storage, never reset
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end
    // pointers wrap at DEPTH; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
            if (pop) rptr <= (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
    assign valid = count != '0;
    assign pop_data = valid ? mem[rptr] : '0;
endmodule

// File: rtl/ntt_buffer_ram.sv
// ntt_buffer_ram: N/E-row coefficient buffer, engine port plus handshaked host port; define BUFFER_RAM_BYPASS_EN to forward same-edge writes to reads
module ntt_buffer_ram
    import ntt_buffer_ram_pkg::*;
#(
    parameter int N = POLY_N,
    parameter int E = ROW_E,
    parameter int FSIZE = COEF_FSIZE,
    parameter int READ_LATENCY = BUFFER_READ_LATENCY,
    parameter int RESP_DEPTH = READ_LATENCY + 2,
    localparam int ADDR_W = $clog2(N) - $clog2(E)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  engine_busy,
    input  BufferRAMTEFsizeInputs ram_inputs,
    output logic [E*FSIZE-1:0]    ram_outputs_rdata,
    input  logic                  host_wr_valid,
    output logic                  host_wr_ready,
    input  logic [ADDR_W-1:0]     host_wr_addr,
    input  logic [E*FSIZE-1:0]    host_wr_data,
    input  logic                  host_rd_valid,
    output logic                  host_rd_ready,
    input  logic [ADDR_W-1:0]     host_rd_addr,
    output logic                  host_resp_valid,
    input  logic                  host_resp_ready,
    output logic [E*FSIZE-1:0]    host_resp_data
);
    localparam int ROWS = N / E;
    localparam int DW = E * FSIZE;
    localparam int FC_W = $clog2(RESP_DEPTH + 1);
    localparam int CNT_W = $clog2(RESP_DEPTH + READ_LATENCY + 1);
    logic [DW-1:0] mem [ROWS];
    logic [DW-1:0] data_pipe [READ_LATENCY];
    logic [READ_LATENCY-1:0] tag_pipe;
    logic [FC_W-1:0] fifo_count;
    logic [CNT_W-1:0] inflight;
    logic host_wr_fire, host_rd_fire, we;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [DW-1:0] wdata, rd_row;
    assign host_wr_ready = !rst && !engine_busy && !ram_inputs.wren;
    assign host_wr_fire = host_wr_valid && host_wr_ready;
    assign host_rd_fire = host_rd_valid && host_rd_ready;
    // write port arbitration (engine always wins) and read port ownership
    always_comb begin
        we = ram_inputs.wren || host_wr_fire;
        waddr = ram_inputs.wren ? ram_inputs.waddr : host_wr_addr;
        wdata = ram_inputs.wren ? ram_inputs.wdata : host_wr_data;
        raddr = engine_busy ? ram_inputs.raddr : host_rd_addr;
`ifdef BUFFER_RAM_BYPASS_EN
        rd_row = (we && waddr == raddr) ? wdata : mem[raddr];
`else
        rd_row = mem[raddr];
`endif
    end
    // credit check: every accepted read holds a FIFO slot until popped
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CNT_W'(tag_pipe[i]);
        host_rd_ready = !rst && !engine_busy && (CNT_W'(fifo_count) + inflight < CNT_W'(RESP_DEPTH));
    end
    // memory write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // read data pipeline, first stage is the memory read register
    always_ff @(posedge clk) begin
        data_pipe[0] <= rd_row;
        for (int i = 1; i < READ_LATENCY; i++) data_pipe[i] <= data_pipe[i - 1];
    end
    // host tag pipeline and registered engine output
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_pipe <= '0;
            ram_outputs_rdata <= '0;
        end else begin
            tag_pipe <= (tag_pipe << 1) | READ_LATENCY'(host_rd_fire);
            ram_outputs_rdata <= data_pipe[READ_LATENCY - 1];
        end
    end
    ntt_buffer_resp_fifo #(.W(DW), .DEPTH(RESP_DEPTH)) u_resp_fifo (
        .clk(clk),
        .rst(rst),
        .push(tag_pipe[READ_LATENCY - 1]),
        .push_data(data_pipe[READ_LATENCY - 1]),
        .pop(host_resp_valid && host_resp_ready),
        .valid(host_resp_valid),
        .pop_data(host_resp_data),
        .count(fifo_count)
    );
endmodule

// File: tb/tb_ntt_buffer_ram.sv
// tb_ntt_buffer_ram: directed self-checking bench for ntt_buffer_ram
module tb_ntt_buffer_ram;
    import ntt_buffer_ram_pkg::*;
    localparam int DW = ROW_E * COEF_FSIZE;
    localparam int ROWS = POLY_N / ROW_E;
    localparam int L = 2;
    logic clk = 1'b0;
    logic rst, engine_busy;
    BufferRAMTEFsizeInputs ram_in;
    logic [DW-1:0] ram_outputs_rdata;
    logic host_wr_valid, host_wr_ready;
    logic [BUF_ADDR_W-1:0] host_wr_addr, host_rd_addr;
    logic [DW-1:0] host_wr_data, host_resp_data;
    logic host_rd_valid, host_rd_ready, host_resp_valid, host_resp_ready;
    logic [DW-1:0] exp_mem [ROWS];
    int tests = 0;
    int fails = 0;

    ntt_buffer_ram dut (
        .clk(clk), .rst(rst), .engine_busy(engine_busy), .ram_inputs(ram_in),
        .ram_outputs_rdata(ram_outputs_rdata),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready), .host_rd_addr(host_rd_addr),
        .host_resp_valid(host_resp_valid), .host_resp_ready(host_resp_ready),
        .host_resp_data(host_resp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rep(input logic [15:0] v);
        return {4{v}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic engine_read(input logic [BUF_ADDR_W-1:0] a, output logic [DW-1:0] d);
        engine_busy = 1'b1;
        ram_in.raddr = a;
        tick();
        repeat (L) tick();
        d = ram_outputs_rdata;
        engine_busy = 1'b0;
    endtask

    task automatic cycle(input bit rd_req, input logic [BUF_ADDR_W-1:0] a,
                         output bit acc, output bit pop, output logic [DW-1:0] d);
        host_rd_valid = rd_req;
        host_rd_addr = a;
        #1;
        acc = host_rd_valid && host_rd_ready;
        pop = host_resp_valid && host_resp_ready;
        d = host_resp_data;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        engine_busy = 1'b0;
        ram_in = '0;
        host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
        host_rd_valid = 1'b0; host_rd_addr = '0; host_resp_ready = 1'b0;
        #1;
        tests++; if (host_wr_ready !== 1'b0) begin fails++; $display("FAIL rst_wr_ready got %b exp 0", host_wr_ready); end
        tests++; if (host_rd_ready !== 1'b0) begin fails++; $display("FAIL rst_rd_ready got %b exp 0", host_rd_ready); end
        tick(); tick();
        tests++; if (ram_outputs_rdata !== '0) begin fails++; $display("FAIL rst_rdata got %h exp 0", ram_outputs_rdata); end
        tests++; if (host_resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got %b exp 0", host_resp_valid); end
        tests++; if (host_resp_data !== '0) begin fails++; $display("FAIL rst_resp_data got %h exp 0", host_resp_data); end
        rst = 1'b0;
        #1;
        tests++; if (host_wr_ready !== 1'b1) begin fails++; $display("FAIL post_rst_wr_ready got %b exp 1", host_wr_ready); end
        tests++; if (host_rd_ready !== 1'b1) begin fails++; $display("FAIL post_rst_rd_ready got %b exp 1", host_rd_ready); end
    endtask

    task automatic test_load_engine_read();
        for (int r = 0; r < ROWS; r++) begin
            host_wr_valid = 1'b1;
            host_wr_addr = BUF_ADDR_W'(r);
            host_wr_data = rep(16'(r));
            exp_mem[r] = rep(16'(r));
            #1;
            tests++; if (host_wr_ready !== 1'b1) begin fails++; $display("FAIL load_wr_ready row %0d got %b exp 1", r, host_wr_ready); end
            tick();
        end
        host_wr_valid = 1'b0;
        engine_busy = 1'b1;
        for (int j = 0; j < ROWS + L; j++) begin
            ram_in.raddr = (j < ROWS) ? BUF_ADDR_W'(j) : '0;
            tick();
            if (j >= L) begin
                tests++;
                if (ram_outputs_rdata !== rep(16'(j - L))) begin
                    fails++; $display("FAIL engine_sweep row %0d got %h exp %h", j - L, ram_outputs_rdata, rep(16'(j - L)));
                end
            end
        end
        tests++; if (host_rd_ready !== 1'b0) begin fails++; $display("FAIL busy_rd_ready got %b exp 0", host_rd_ready); end
        engine_busy = 1'b0;
    endtask

    task automatic test_contention();
        logic [DW-1:0] d;
        logic [15:0] v;
        host_wr_valid = 1'b1;
        host_wr_addr = 4'd7;
        host_wr_data = rep(16'h0077);
        for (int i = 0; i < 3; i++) begin
            v = 16'h0088 + 16'(i) * 16'h0011;
            ram_in.wren = 1'b1;
            ram_in.waddr = BUF_ADDR_W'(8 + i);
            ram_in.wdata = rep(v);
            exp_mem[8 + i] = rep(v);
            #1;
            tests++; if (host_wr_ready !== 1'b0) begin fails++; $display("FAIL contention_ready cycle %0d got %b exp 0", i, host_wr_ready); end
            tick();
        end
        ram_in.wren = 1'b0;
        #1;
        tests++; if (host_wr_ready !== 1'b1) begin fails++; $display("FAIL contention_release got %b exp 1", host_wr_ready); end
        tick();
        host_wr_valid = 1'b0;
        exp_mem[7] = rep(16'h0077);
        for (int r = 7; r <= 10; r++) begin
            engine_read(BUF_ADDR_W'(r), d);
            tests++; if (d !== exp_mem[r]) begin fails++; $display("FAIL contention_row %0d got %h exp %h", r, d, exp_mem[r]); end
        end
    endtask

    task automatic test_host_latency();
        host_resp_ready = 1'b0;
        host_rd_valid = 1'b1;
        host_rd_addr = 4'd3;
        #1;
        tests++; if (host_rd_ready !== 1'b1) begin fails++; $display("FAIL lat_rd_ready got %b exp 1", host_rd_ready); end
        tick();
        host_rd_valid = 1'b0;
        tests++; if (host_resp_valid !== 1'b0) begin fails++; $display("FAIL lat_t0 got %b exp 0", host_resp_valid); end
        tick();
        tests++; if (host_resp_valid !== 1'b0) begin fails++; $display("FAIL lat_t1 got %b exp 0", host_resp_valid); end
        tick();
        tests++; if (host_resp_valid !== 1'b1) begin fails++; $display("FAIL lat_t2 got %b exp 1", host_resp_valid); end
        tests++; if (host_resp_data !== exp_mem[3]) begin fails++; $display("FAIL lat_data got %h exp %h", host_resp_data, exp_mem[3]); end
        host_resp_ready = 1'b1;
        tick();
        host_resp_ready = 1'b0;
        tests++; if (host_resp_valid !== 1'b0) begin fails++; $display("FAIL lat_pop got %b exp 0", host_resp_valid); end
    endtask

    task automatic test_backpressure();
        int issued = 0;
        int got = 0;
        bit acc, pop;
        logic [DW-1:0] d;
        host_resp_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cycle(issued < 10, BUF_ADDR_W'(issued), acc, pop, d);
            if (acc) issued++;
        end
        tests++; if (issued != 4) begin fails++; $display("FAIL bp_accepted got %0d exp 4", issued); end
        host_resp_ready = 1'b1;
        for (int c = 0; c < 60 && got < 10; c++) begin
            cycle(issued < 10, BUF_ADDR_W'(issued), acc, pop, d);
            if (acc) issued++;
            if (pop) begin
                tests++;
                if (d !== exp_mem[got]) begin fails++; $display("FAIL bp_order resp %0d got %h exp %h", got, d, exp_mem[got]); end
                got++;
            end
        end
        tests++; if (got != 10) begin fails++; $display("FAIL bp_count got %0d exp 10", got); end
        host_rd_valid = 1'b0;
        host_resp_ready = 1'b0;
    endtask

    task automatic test_bypass();
        logic [DW-1:0] d, e;
        engine_busy = 1'b1;
        ram_in.raddr = 4'd5;
        ram_in.wren = 1'b1;
        ram_in.waddr = 4'd5;
        ram_in.wdata = rep(16'h00B0);
        tick();
        ram_in.wren = 1'b0;
        repeat (L) tick();
        d = ram_outputs_rdata;
`ifdef BUFFER_RAM_BYPASS_EN
        e = rep(16'h00B0);
`else
        e = exp_mem[5];
`endif
        tests++; if (d !== e) begin fails++; $display("FAIL bypass_engine got %h exp %h", d, e); end
        exp_mem[5] = rep(16'h00B0);
        engine_busy = 1'b0;
        host_resp_ready = 1'b0;
        host_rd_valid = 1'b1;
        host_rd_addr = 4'd5;
        ram_in.wren = 1'b1;
        ram_in.wdata = rep(16'h00C0);
        tick();
        host_rd_valid = 1'b0;
        ram_in.wren = 1'b0;
        repeat (L) tick();
`ifdef BUFFER_RAM_BYPASS_EN
        e = rep(16'h00C0);
`else
        e = exp_mem[5];
`endif
        tests++; if (host_resp_valid !== 1'b1) begin fails++; $display("FAIL bypass_host_valid got %b exp 1", host_resp_valid); end
        tests++; if (host_resp_data !== e) begin fails++; $display("FAIL bypass_host got %h exp %h", host_resp_data, e); end
        exp_mem[5] = rep(16'h00C0);
        host_resp_ready = 1'b1;
        tick();
        host_resp_ready = 1'b0;
    endtask

    task automatic test_ownership();
        int issued = 0;
        int got = 0;
        bit acc, pop;
        logic [DW-1:0] d;
        host_resp_ready = 1'b1;
        for (int c = 0; c < 10 && issued < 2; c++) begin
            cycle(1'b1, BUF_ADDR_W'(1 + issued), acc, pop, d);
            if (acc) issued++;
            if (pop) got++;
        end
        tests++; if (issued != 2) begin fails++; $display("FAIL own_issue got %0d exp 2", issued); end
        engine_busy = 1'b1;
        ram_in.raddr = '0;
        for (int c = 0; c < 8; c++) begin
            cycle(1'b1, 4'd3, acc, pop, d);
            tests++; if (acc || host_rd_ready !== 1'b0) begin fails++; $display("FAIL own_rd_ready cycle %0d got %b exp 0", c, host_rd_ready); end
            if (pop) begin
                tests++;
                if (got < 2 && d !== exp_mem[1 + got]) begin fails++; $display("FAIL own_data resp %0d got %h exp %h", got, d, exp_mem[1 + got]); end
                got++;
            end
        end
        tests++; if (got != 2) begin fails++; $display("FAIL own_count got %0d exp 2", got); end
        engine_busy = 1'b0;
        host_rd_valid = 1'b0;
        host_resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int issued = 0;
        bit acc, pop;
        logic [DW-1:0] d;
        host_resp_ready = 1'b0;
        for (int c = 0; c < 10 && issued < 3; c++) begin
            cycle(1'b1, BUF_ADDR_W'(issued), acc, pop, d);
            if (acc) issued++;
        end
        host_rd_valid = 1'b0;
        tests++; if (issued != 3) begin fails++; $display("FAIL mid_issue got %0d exp 3", issued); end
        rst = 1'b1;
        tick();
        tests++; if (host_resp_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got %b exp 0", host_resp_valid); end
        rst = 1'b0;
        repeat (5) tick();
        tests++; if (host_resp_valid !== 1'b0) begin fails++; $display("FAIL mid_after_valid got %b exp 0", host_resp_valid); end
        tests++; if (host_resp_data !== '0) begin fails++; $display("FAIL mid_after_data got %h exp 0", host_resp_data); end
        tests++; if (host_rd_ready !== 1'b1) begin fails++; $display("FAIL mid_after_ready got %b exp 1", host_rd_ready); end
    endtask

    initial begin
        test_reset();
        test_load_engine_read();
        test_contention();
        test_host_latency();
        test_backpressure();
        test_bypass();
        test_ownership();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
